// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared constants for the memory-stage access controller
//
// Purpose: defines the controller state encoding, the error read pattern, and
//          the default parameter values.
// Ports:   none (package)
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    MEMC_IDLE = 2'b00,
    MEMC_LO   = 2'b01,
    MEMC_HI   = 2'b10,
    MEMC_DONE = 2'b11
  } memc_state_e;

  // Load result reported when a byte transfer never gets acknowledged.
  localparam logic [15:0] MEM_ERR_DATA = 16'hFFFF;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int DEFAULT_ADDR_W  = 16;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - CPU memory-stage and external byte-bus interfaces
//
// Purpose: groups the CPU-side request handshake and the 8-bit external bus.
// Ports:   mem_req_if - req/we/byte_mode/addr/wdata from the CPU, mem_wait/rdata/mem_err back
//          mem_bus_if - bus_addr/bus_wdata/bus_req/bus_we out, bus_rdata/bus_ack back
interface mem_req_if
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  logic              req;
  logic              we;
  logic              byte_mode;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic              mem_wait;
  logic [15:0]       rdata;
  logic              mem_err;

  modport master (output req, we, byte_mode, addr, wdata,
                  input  mem_wait, rdata, mem_err);
  modport slave  (input  req, we, byte_mode, addr, wdata,
                  output mem_wait, rdata, mem_err);
endinterface

interface mem_bus_if
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic [7:0]        bus_rdata;
  logic              bus_req;
  logic              bus_we;
  logic              bus_ack;

  modport master (output bus_addr, bus_wdata, bus_req, bus_we,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_addr, bus_wdata, bus_req, bus_we,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage responder running one or two byte transfers
//
// Purpose: accepts the CPU memory-stage request, performs a byte or little-endian
//          word access on the 8-bit bus, stalls the CPU via mem_wait until done.
// Ports:   clk, rst (sync active-high)
//          cpu - mem_req_if.slave  (request in, mem_wait/rdata/mem_err out)
//          bus - mem_bus_if.master (byte transfers out, bus_rdata/bus_ack in)
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic      clk,
  input  logic      rst,
  mem_req_if.slave  cpu,
  mem_bus_if.master bus
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  memc_state_e       state, state_nxt;
  logic              we_q;
  logic              byte_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [15:0]       cnt;
  logic [15:0]       rdata_q;
  logic              err_q;

  logic              xfer;
  logic              ack;
  logic              expire;
  logic              bus_req_c;
  logic              bus_we_c;
  logic [ADDR_W-1:0] bus_addr_c;
  logic [7:0]        bus_wdata_c;

  assign xfer   = (state == MEMC_LO) || (state == MEMC_HI);
  // bus_req is high exactly when xfer is, so acks outside a transfer are dropped here.
  assign ack    = xfer && bus.bus_ack;
  assign expire = xfer && !bus.bus_ack && (cnt == CNT_LAST);

  // Combinational so the CPU sees the stall in its very first MEM cycle.
  assign cpu.mem_wait = cpu.req && (state != MEMC_DONE);
  assign cpu.rdata    = rdata_q;
  assign cpu.mem_err  = err_q;

  assign bus.bus_req   = bus_req_c;
  assign bus.bus_we    = bus_we_c;
  assign bus.bus_addr  = bus_addr_c;
  assign bus.bus_wdata = bus_wdata_c;

  always_ff @(posedge clk) begin
    if (rst) state <= MEMC_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus_req_c   = 1'b0;
    bus_we_c    = 1'b0;
    bus_addr_c  = '0;
    bus_wdata_c = '0;
    case (state)
      MEMC_IDLE: if (cpu.req) state_nxt = MEMC_LO;
      MEMC_LO: begin
        bus_req_c   = 1'b1;
        bus_we_c    = we_q;
        bus_addr_c  = byte_q ? addr_q : {addr_q[ADDR_W-1:1], 1'b0};
        bus_wdata_c = wdata_q[7:0];
        if (ack)         state_nxt = byte_q ? MEMC_DONE : MEMC_HI;
        else if (expire) state_nxt = MEMC_DONE;
      end
      MEMC_HI: begin
        // High byte is the address with bit 0 forced, never addr+1.
        bus_req_c   = 1'b1;
        bus_we_c    = we_q;
        bus_addr_c  = {addr_q[ADDR_W-1:1], 1'b1};
        bus_wdata_c = wdata_q[15:8];
        if (ack || expire) state_nxt = MEMC_DONE;
      end
      MEMC_DONE: state_nxt = MEMC_IDLE;
      default:   state_nxt = MEMC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == MEMC_IDLE) begin
      if (cpu.req) begin
        we_q    <= cpu.we;
        byte_q  <= cpu.byte_mode;
        addr_q  <= cpu.addr;
        wdata_q <= cpu.wdata;
        cnt     <= '0;
        err_q   <= 1'b0;
      end
    end else if (xfer) begin
      if (ack) begin
        cnt <= '0;
        if (!we_q) begin
          if (byte_q)                rdata_q        <= {8'h00, bus.bus_rdata};
          else if (state == MEMC_LO) rdata_q[7:0]   <= bus.bus_rdata;
          else                       rdata_q[15:8]  <= bus.bus_rdata;
        end
      end else if (expire) begin
        err_q <= 1'b1;
        if (!we_q) rdata_q <= MEM_ERR_DATA;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule
